// File: rtl/fir_input_sequencer_pkg.sv
// Shared types and constants for the FIR input sequencer.
package fir_input_sequencer_pkg;

  localparam int DATA_W     = 6;
  localparam int CFG_WORDS  = 3;
  localparam int CFG_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_CFG    = 2'd2
  } state_t;

endpackage

// File: rtl/fir_input_sequencer_if.sv
// Pin-side word inputs (master drives) and FIR-side stream/status outputs (slave drives).
interface fir_input_sequencer_if
  import fir_input_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic signed [DATA_W-1:0] ui_data;
  logic                     ui_strobe;
  logic                     ui_mode;
  logic                     ui_run;
  logic                     ui_clr_flags;
  logic signed [DATA_W-1:0] x_n;
  logic                     s_axis_fir_tvalid;
  logic                     s_set_coeffs;
  logic [LVL_W-1:0]         fifo_level;
  logic                     overrun;
  logic                     underrun;

  modport master (
    output ui_data, ui_strobe, ui_mode, ui_run, ui_clr_flags,
    input  x_n, s_axis_fir_tvalid, s_set_coeffs, fifo_level, overrun, underrun
  );

  modport slave (
    input  ui_data, ui_strobe, ui_mode, ui_run, ui_clr_flags,
    output x_n, s_axis_fir_tvalid, s_set_coeffs, fifo_level, overrun, underrun
  );

endinterface

// File: rtl/fir_input_sequencer_fifo.sv
// fir_sample_fifo: small synchronous sample FIFO; a push into a full FIFO is accepted when a pop frees the slot.
module fir_sample_fifo
  import fir_input_sequencer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [LW-1:0]            o_level
);
  logic signed [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]            r_wr;
  logic [AW-1:0]            r_rd;
  logic [LW-1:0]            r_level;
  logic                     w_push;
  logic                     w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd];
  assign o_level = r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_input_sequencer.sv
// Front end of the 6-bit FIR: strobed samples stream through a FIFO, coefficient triplets replay as a set_coeffs burst.
// Optional macro HOLD_LAST_EN: on underrun repeat the last popped sample instead of zero-stuffing.
module fir_input_sequencer
  import fir_input_sequencer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SYNC_STG = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_input_sequencer_if.slave bus
);
  localparam int         LVL_W    = $clog2(DEPTH + 1);
  localparam logic [1:0] CNT_LAST = 2'(CFG_WORDS - 1);
  localparam logic [1:0] K_LAST   = 2'(CFG_CYCLES - 1);

  logic [SYNC_STG-1:0]      r_strb_sync, r_run_sync, r_clr_sync;
  logic                     r_strb_d, r_ev_p0, r_mode_p0;
  logic signed [DATA_W-1:0] r_word_p0;
  logic signed [DATA_W-1:0] r_cfg [CFG_WORDS];
  logic [1:0]               r_cfg_cnt, r_k, w_k_nxt;
  logic                     r_cfg_pend;
  state_t                   r_state, w_state_nxt;
  logic signed [DATA_W-1:0] r_x_n, w_x_nxt, w_head, w_fill;
  logic                     r_tvalid, r_set, r_over, r_under;
  logic                     w_tvalid_nxt, w_set_nxt, w_pop, w_under_set, w_over_set;
  logic                     w_rise, w_run_s, w_clr_s, w_samp_ev, w_coef_ev, w_coef_drop, w_cfg_done;
  logic                     w_full, w_empty;
  logic [LVL_W-1:0]         w_level;

  assign w_rise      = r_strb_sync[SYNC_STG-1] & ~r_strb_d;
  assign w_run_s     = r_run_sync[SYNC_STG-1];
  assign w_clr_s     = r_clr_sync[SYNC_STG-1];
  assign w_samp_ev   = r_ev_p0 & ~r_mode_p0;
  assign w_coef_ev   = r_ev_p0 & r_mode_p0;
  assign w_coef_drop = w_coef_ev & (r_cfg_pend | (r_state == ST_CFG));
  assign w_cfg_done  = (r_state == ST_CFG) && (r_k == K_LAST);
  assign w_over_set  = w_coef_drop | (w_samp_ev & w_full & ~w_pop);

  // Stage p0: synchronize async pins, register the strobe edge and capture the word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strb_sync <= '0;
      r_run_sync  <= '0;
      r_clr_sync  <= '0;
      r_strb_d    <= 1'b0;
      r_ev_p0     <= 1'b0;
      r_mode_p0   <= 1'b0;
      r_word_p0   <= '0;
    end else begin
      r_strb_sync <= {r_strb_sync[SYNC_STG-2:0], bus.ui_strobe};
      r_run_sync  <= {r_run_sync[SYNC_STG-2:0], bus.ui_run};
      r_clr_sync  <= {r_clr_sync[SYNC_STG-2:0], bus.ui_clr_flags};
      r_strb_d    <= r_strb_sync[SYNC_STG-1];
      r_ev_p0     <= w_rise;
      if (w_rise) begin
        r_word_p0 <= bus.ui_data;
        r_mode_p0 <= bus.ui_mode;
      end
    end
  end

  fir_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_samp_ev),
    .i_pop   (w_pop),
    .i_data  (r_word_p0),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // A burst is only armed once all three words are in; partial triplets die with reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CFG_WORDS; i++) r_cfg[i] <= '0;
      r_cfg_cnt  <= '0;
      r_cfg_pend <= 1'b0;
    end else begin
      if (w_cfg_done) r_cfg_pend <= 1'b0;
      if (w_coef_ev && !w_coef_drop) begin
        r_cfg[r_cfg_cnt] <= r_word_p0;
        if (r_cfg_cnt == CNT_LAST) begin
          r_cfg_cnt  <= '0;
          r_cfg_pend <= 1'b1;
        end else begin
          r_cfg_cnt <= r_cfg_cnt + 2'd1;
        end
      end
    end
  end

`ifdef HOLD_LAST_EN
  logic signed [DATA_W-1:0] r_last;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_last <= '0;
    else if (w_pop) r_last <= w_head;
  end
  assign w_fill = r_last;
`else
  assign w_fill = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (r_cfg_pend) begin
          w_state_nxt = ST_CFG;
          w_k_nxt     = '0;
        end else if (w_run_s) begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (r_cfg_pend) begin
          w_state_nxt = ST_CFG;
          w_k_nxt     = '0;
        end else if (!w_run_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CFG: begin
        if (r_k == K_LAST) begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt = r_k + 2'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are precomputed for the state being entered so they register together with it
  always_comb begin
    w_pop        = 1'b0;
    w_tvalid_nxt = 1'b0;
    w_set_nxt    = 1'b0;
    w_x_nxt      = '0;
    w_under_set  = 1'b0;
    case (w_state_nxt)
      ST_STREAM: begin
        w_tvalid_nxt = 1'b1;
        if (w_empty) begin
          w_under_set = 1'b1;
          w_x_nxt     = w_fill;
        end else begin
          w_pop   = 1'b1;
          w_x_nxt = w_head;
        end
      end
      ST_CFG: begin
        w_set_nxt = (w_k_nxt != K_LAST);
        if (w_k_nxt != 2'd0) w_x_nxt = r_cfg[w_k_nxt - 2'd1];
      end
      default: ;
    endcase
  end

  // Stage p1: FSM state and registered FIR-facing outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_x_n    <= '0;
      r_tvalid <= 1'b0;
      r_set    <= 1'b0;
      r_over   <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_x_n    <= w_x_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_set    <= w_set_nxt;
      if (w_over_set)   r_over <= 1'b1;
      else if (w_clr_s) r_over <= 1'b0;
      if (w_under_set)  r_under <= 1'b1;
      else if (w_clr_s) r_under <= 1'b0;
    end
  end

  assign bus.x_n               = r_x_n;
  assign bus.s_axis_fir_tvalid = r_tvalid;
  assign bus.s_set_coeffs      = r_set;
  assign bus.fifo_level        = w_level;
  assign bus.overrun           = r_over;
  assign bus.underrun          = r_under;

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Directed bench for fir_input_sequencer: streaming, overflow, coefficient bursts, async reset and flag clearing.
module tb_fir_input_sequencer;
  localparam int DEPTH    = 4;
  localparam int SYNC_STG = 2;
`ifdef HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   saw;

  always #5 clk = ~clk;

  fir_input_sequencer_if #(.DEPTH(DEPTH)) bus ();

  fir_input_sequencer #(.DEPTH(DEPTH), .SYNC_STG(SYNC_STG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b1;
    bus.ui_strobe    = 1'b0;
    bus.ui_run       = 1'b0;
    bus.ui_clr_flags = 1'b0;
    bus.ui_mode      = 1'b0;
    bus.ui_data      = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Returns at the negedge after the word has been stored (4 edges after the strobe rose)
  task automatic strobe_rise(input int d, input bit m);
    bus.ui_data = 6'(d);
    bus.ui_mode = m;
    @(negedge clk);
    bus.ui_strobe = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic strobe_fall();
    bus.ui_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input int d, input bit m);
    strobe_rise(d, m);
    strobe_fall();
  endtask

  task automatic watch_set(input int cycles, output bit seen);
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.s_set_coeffs) seen = 1'b1;
    end
  endtask

  int exp_x  [4] = '{0, -20, 21, -1};
  int exp_st [4] = '{1, 1, 1, 0};

  initial begin
    reset = 1'b1;
    do_reset();

    // reset state
    chk("rst_x_n",     int'(bus.x_n), 0);
    chk("rst_tvalid",  int'(bus.s_axis_fir_tvalid), 0);
    chk("rst_set",     int'(bus.s_set_coeffs), 0);
    chk("rst_level",   int'(bus.fifo_level), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_underrun", int'(bus.underrun), 0);

    // 1: run with empty FIFO -> zero-stuffed stream
    bus.ui_run = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_tvalid",   int'(bus.s_axis_fir_tvalid), 1);
    chk("t1_x_n",      int'(bus.x_n), 0);
    chk("t1_underrun", int'(bus.underrun), 1);
    @(negedge clk);
    chk("t1_tvalid2",  int'(bus.s_axis_fir_tvalid), 1);
    chk("t1_x_n2",     int'(bus.x_n), 0);

    // 2: three samples then stream
    do_reset();
    send_word(5, 1'b0);
    send_word(-3, 1'b0);
    send_word(7, 1'b0);
    chk("t2_level3", int'(bus.fifo_level), 3);
    chk("t2_idle_tvalid", int'(bus.s_axis_fir_tvalid), 0);
    bus.ui_run = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_x0", int'(bus.x_n), 5);
    chk("t2_lvl2", int'(bus.fifo_level), 2);
    @(negedge clk);
    chk("t2_x1", int'(bus.x_n), -3);
    chk("t2_lvl1", int'(bus.fifo_level), 1);
    @(negedge clk);
    chk("t2_x2", int'(bus.x_n), 7);
    chk("t2_lvl0", int'(bus.fifo_level), 0);
    chk("t2_no_underrun", int'(bus.underrun), 0);
    @(negedge clk);
    chk("t2_fill", int'(bus.x_n), HOLD ? 7 : 0);
    chk("t2_underrun", int'(bus.underrun), 1);
    chk("t2_tvalid", int'(bus.s_axis_fir_tvalid), 1);

    // 3: overflow with run low
    do_reset();
    for (int i = 1; i <= DEPTH; i++) send_word(i, 1'b0);
    chk("t3_full_level", int'(bus.fifo_level), 4);
    chk("t3_no_overrun", int'(bus.overrun), 0);
    send_word(DEPTH + 1, 1'b0);
    chk("t3_level_sat", int'(bus.fifo_level), 4);
    chk("t3_overrun", int'(bus.overrun), 1);
    bus.ui_run = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("t3_x", int'(bus.x_n), i);
      @(negedge clk);
    end
    chk("t3_no_fifth", int'(bus.x_n), HOLD ? 4 : 0);

    // 4: coefficient burst while streaming
    do_reset();
    bus.ui_run = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_streaming", int'(bus.s_axis_fir_tvalid), 1);
    send_word(6'h2C, 1'b1);
    send_word(6'h15, 1'b1);
    strobe_rise(6'h3F, 1'b1);
    chk("t4_pre_tvalid", int'(bus.s_axis_fir_tvalid), 1);
    chk("t4_pre_set", int'(bus.s_set_coeffs), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_set", int'(bus.s_set_coeffs), exp_st[k]);
      chk("t4_tvalid", int'(bus.s_axis_fir_tvalid), 0);
      chk("t4_x_n", int'(bus.x_n), exp_x[k]);
    end
    @(negedge clk);
    chk("t4_idle_set", int'(bus.s_set_coeffs), 0);
    chk("t4_idle_tvalid", int'(bus.s_axis_fir_tvalid), 0);
    @(negedge clk);
    chk("t4_resume", int'(bus.s_axis_fir_tvalid), 1);
    chk("t4_excl", int'(bus.s_axis_fir_tvalid & bus.s_set_coeffs), 0);
    strobe_fall();

    // 5: async reset in the middle of a burst
    do_reset();
    send_word(6'h2C, 1'b1);
    send_word(6'h15, 1'b1);
    strobe_rise(6'h3F, 1'b1);
    bus.ui_strobe = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_k2_set", int'(bus.s_set_coeffs), 1);
    chk("t5_k2_x", int'(bus.x_n), 21);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_x", int'(bus.x_n), 0);
    chk("t5_async_set", int'(bus.s_set_coeffs), 0);
    @(negedge clk);
    reset = 1'b0;
    watch_set(8, saw);
    chk("t5_no_resume", int'(saw), 0);
    chk("t5_idle", int'(bus.s_axis_fir_tvalid), 0);
    // partial triplet must be discarded by reset
    send_word(1, 1'b1);
    do_reset();
    send_word(2, 1'b1);
    send_word(3, 1'b1);
    watch_set(10, saw);
    chk("t5_partial_cleared", int'(saw), 0);
    strobe_rise(4, 1'b1);
    watch_set(6, saw);
    chk("t5_third_fires", int'(saw), 1);
    strobe_fall();

    // 6: fourth coefficient word during a burst, then clear flags
    do_reset();
    send_word(6'h2C, 1'b1);
    send_word(6'h15, 1'b1);
    strobe_rise(6'h3F, 1'b1);
    bus.ui_strobe = 1'b0;
    bus.ui_data   = 6'h11;
    @(negedge clk);
    chk("t6_k0_set", int'(bus.s_set_coeffs), 1);
    bus.ui_strobe = 1'b1;
    @(negedge clk);
    chk("t6_k1_x", int'(bus.x_n), -20);
    @(negedge clk);
    chk("t6_k2_x", int'(bus.x_n), 21);
    @(negedge clk);
    chk("t6_k3_x", int'(bus.x_n), -1);
    chk("t6_pre_overrun", int'(bus.overrun), 0);
    @(negedge clk);
    chk("t6_overrun", int'(bus.overrun), 1);
    chk("t6_set_low", int'(bus.s_set_coeffs), 0);
    bus.ui_strobe = 1'b0;
    repeat (4) @(negedge clk);
    bus.ui_clr_flags = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_clr_wait", int'(bus.overrun), 1);
    @(negedge clk);
    chk("t6_cleared", int'(bus.overrun), 0);
    bus.ui_clr_flags = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
